// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the stopwatch run-control block: FSM encoding,
// rate-select codes and default prescaler terminal values.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  localparam logic [1:0] RATE_SLOW     = 2'b00;
  localparam logic [1:0] RATE_MED      = 2'b01;
  localparam logic [1:0] RATE_FAST     = 2'b10;
  localparam logic [1:0] RATE_SLOW_ALT = 2'b11;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam logic [31:0] DEF_TOP_SLOW = 32'd99_999_999;
  localparam logic [31:0] DEF_TOP_MED  = 32'd9_999_999;
  localparam logic [31:0] DEF_TOP_FAST = 32'd999_999;

  // Map a rate-select code onto its prescaler terminal value.
  function automatic logic [31:0] sel_top(input logic [1:0]  sel,
                                          input logic [31:0] top_slow,
                                          input logic [31:0] top_med,
                                          input logic [31:0] top_fast);
    case (sel)
      RATE_SLOW, RATE_SLOW_ALT: sel_top = top_slow;
      RATE_MED:                 sel_top = top_med;
      RATE_FAST:                sel_top = top_fast;
      default:                  sel_top = top_slow;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// single-cycle pulse on each accepted rising edge of the debounced level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             level_r;
  logic             level_d_r;
  logic             press_r;

  // Bring the raw button into the Clk domain.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], btn_raw};
    end
  end

  // The level only flips after the synchronized input has differed for
  // DEBOUNCE_CYCLES consecutive samples; any return resets the count.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= 1'b0;
    end else if (sync_r[1] == level_r) begin
      cnt_r   <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r   <= {CNT_W{1'b0}};
      level_r <= sync_r[1];
    end else begin
      cnt_r   <= cnt_r + CNT_W'(1);
    end
  end

  // Registered rising-edge detect of the debounced level.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      level_d_r <= 1'b0;
      press_r   <= 1'b0;
    end else begin
      level_d_r <= level_r;
      press_r   <= level_r & ~level_d_r;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run-control sequencer for the BCD stopwatch: start/pause/clear FSM and
// a rate-selectable prescaler producing count-enable and clear pulses.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [31:0] TOP_SLOW        = DEF_TOP_SLOW,
  parameter logic [31:0] TOP_MED         = DEF_TOP_MED,
  parameter logic [31:0] TOP_FAST        = DEF_TOP_FAST
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnStartStop,
  input  logic       BtnClear,
  input  logic [1:0] RateSel,
  output logic       CountEn,
  output logic       CountClr,
  output logic       Running,
  output logic       Paused
);

  logic [1:0]  rst_sync_r;
  logic        rst_n_s;
  logic [1:0]  rate_meta_r;
  logic [1:0]  rate_sync_r;
  logic [1:0]  rate_r;
  logic        ss_press_s;
  logic        clr_press_s;
  state_e      state_r;
  state_e      next_state_s;
  logic [31:0] presc_r;
  logic [31:0] presc_next_s;
  logic [31:0] top_s;
  logic        rate_chg_s;
  logic        term_s;
  logic        tick_s;
  logic        count_en_r;
  logic        count_clr_r;
  logic        running_r;
  logic        paused_r;

  // Reset asserts immediately and releases two clocks later.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_r[1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
    .Clk     (Clk),
    .Reset   (rst_n_s),
    .btn_raw (BtnStartStop),
    .press   (ss_press_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .Clk     (Clk),
    .Reset   (rst_n_s),
    .btn_raw (BtnClear),
    .press   (clr_press_s)
  );

  // Synchronize the rate switches and keep a registered copy for change detect.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      rate_meta_r <= 2'b00;
      rate_sync_r <= 2'b00;
      rate_r      <= 2'b00;
    end else begin
      rate_meta_r <= RateSel;
      rate_sync_r <= rate_meta_r;
      rate_r      <= rate_sync_r;
    end
  end

  // Next-state and prescaler decision; Clear outranks StartStop.
  always_comb begin
    rate_chg_s   = (rate_sync_r != rate_r);
    top_s        = sel_top(rate_r, TOP_SLOW, TOP_MED, TOP_FAST);
    term_s       = (presc_r == top_s);
    next_state_s = state_r;
    presc_next_s = presc_r;
    tick_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (clr_press_s)     next_state_s = ST_CLEAR;
        else if (ss_press_s) next_state_s = ST_RUN;
        else                 next_state_s = ST_IDLE;
      end
      ST_RUN: begin
        if (clr_press_s)     next_state_s = ST_CLEAR;
        else if (ss_press_s) next_state_s = ST_PAUSE;
        else                 next_state_s = ST_RUN;
      end
      ST_PAUSE: begin
        if (clr_press_s)     next_state_s = ST_CLEAR;
        else if (ss_press_s) next_state_s = ST_RUN;
        else                 next_state_s = ST_PAUSE;
      end
      ST_CLEAR: next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase

    // A terminal match on the way out of RUN holds at TOP so the tick
    // fires on the first RUN cycle after resume instead.
    if ((state_r == ST_CLEAR) || rate_chg_s) begin
      presc_next_s = 32'd0;
    end else if (state_r == ST_RUN) begin
      if (term_s && (next_state_s == ST_RUN)) begin
        presc_next_s = 32'd0;
        tick_s       = 1'b1;
      end else if (term_s) begin
        presc_next_s = presc_r;
      end else begin
        presc_next_s = presc_r + 32'd1;
      end
    end else begin
      presc_next_s = presc_r;
    end
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge Clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_r     <= ST_IDLE;
      presc_r     <= 32'd0;
      count_en_r  <= 1'b0;
      count_clr_r <= 1'b0;
      running_r   <= 1'b0;
      paused_r    <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      presc_r     <= presc_next_s;
      count_en_r  <= tick_s;
      count_clr_r <= (next_state_s == ST_CLEAR);
      running_r   <= (next_state_s == ST_RUN);
      paused_r    <= (next_state_s == ST_PAUSE);
    end
  end

  assign CountEn  = count_en_r;
  assign CountClr = count_clr_r;
  assign Running  = running_r;
  assign Paused   = paused_r;

endmodule
